// File: rtl/io_bus_master.sv
// IoBus initiator: turns single client requests into one IoBus read/write cycle
// and returns exactly one response (data + status) per accepted request.
module io_bus_master #(
  parameter int unsigned CTimeout  = 16,
  parameter logic [15:0] CAddrMask = 16'hFFFF
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic        AReqValid,
  output logic        AReqReady,
  input  logic        AReqWr,
  input  logic [3:0]  AReqSize,
  input  logic [15:0] AReqAddr,
  input  logic [63:0] AReqData,
  output logic        ARespValid,
  input  logic        ARespReady,
  output logic [63:0] ARespData,
  output logic [1:0]  ARespStat,
  output logic [15:0] AIoAddr,
  output logic [63:0] AIoMosi,
  output logic [3:0]  AIoWrSize,
  output logic [3:0]  AIoRdSize,
  input  logic [63:0] AIoMiso,
  input  logic        AIoAddrAck,
  input  logic        AIoAddrErr
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned STW = 2;

  localparam logic [STW-1:0] StatOk      = 2'd0;
  localparam logic [STW-1:0] StatAddrErr = 2'd1;
  localparam logic [STW-1:0] StatTimeout = 2'd2;
  localparam logic [STW-1:0] StatBadSize = 2'd3;

  localparam logic [CW-1:0] CntLast = CW'(CTimeout - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           resp_valid_q, resp_valid_d;
  logic [DW-1:0]  resp_data_q, resp_data_d;
  logic [STW-1:0] resp_stat_q, resp_stat_d;
  logic [AW-1:0]  io_addr_q, io_addr_d;
  logic [DW-1:0]  io_mosi_q, io_mosi_d;
  logic [SW-1:0]  io_wr_q, io_wr_d;
  logic [SW-1:0]  io_rd_q, io_rd_d;
  logic           size_ok_c;

  // Read data mask from the active read strobe; a write strobe leaves it zero.
  function automatic logic [DW-1:0] rd_mask(input logic [SW-1:0] s);
    logic [DW-1:0] m;
    m = '0;
    case (s)
      4'b0001: m = DW'(64'h0000_0000_0000_00FF);
      4'b0010: m = DW'(64'h0000_0000_0000_FFFF);
      4'b0100: m = DW'(64'h0000_0000_FFFF_FFFF);
      4'b1000: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

  assign size_ok_c = (AReqSize != '0) && ((AReqSize & (AReqSize - SW'(1))) == '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_stat_d  = resp_stat_q;
    io_addr_d    = io_addr_q;
    io_mosi_d    = io_mosi_q;
    io_wr_d      = io_wr_q;
    io_rd_d      = io_rd_q;

    case (state_q)
      StIdle: begin
        if (AReqValid && ready_q) begin
          cnt_d = '0;
          if (!size_ok_c) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_stat_d  = StatBadSize;
          end else begin
            state_d   = StAccess;
            io_addr_d = AReqAddr & CAddrMask;
            io_mosi_d = AReqData;
            io_wr_d   = AReqWr ? AReqSize : '0;
            io_rd_d   = AReqWr ? '0 : AReqSize;
          end
        end
      end

      StAccess: begin
        if (AIoAddrErr || AIoAddrAck || (cnt_q == CntLast)) begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          io_addr_d    = '0;
          io_mosi_d    = '0;
          io_wr_d      = '0;
          io_rd_d      = '0;
          if (AIoAddrErr) begin
            resp_data_d = '0;
            resp_stat_d = StatAddrErr;
          end else if (AIoAddrAck) begin
            resp_data_d = AIoMiso & rd_mask(io_rd_q);
            resp_stat_d = StatOk;
          end else begin
            resp_data_d = '0;
            resp_stat_d = StatTimeout;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      StResp: begin
        if (ARespReady) begin
          state_d      = StIdle;
          cnt_d        = '0;
          resp_valid_d = 1'b0;
          resp_data_d  = '0;
          resp_stat_d  = StatOk;
        end
      end

      default: state_d = StIdle;
    endcase

    // Ready only while sitting in IDLE, so never in the response handshake cycle.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge AClkH) begin
    if (AClkHEn) begin
      if (AResetH) begin
        state_q      <= StIdle;
        ready_q      <= 1'b0;
        cnt_q        <= '0;
        resp_valid_q <= 1'b0;
        resp_data_q  <= '0;
        resp_stat_q  <= StatOk;
        io_addr_q    <= '0;
        io_mosi_q    <= '0;
        io_wr_q      <= '0;
        io_rd_q      <= '0;
      end else begin
        state_q      <= state_d;
        ready_q      <= ready_d;
        cnt_q        <= cnt_d;
        resp_valid_q <= resp_valid_d;
        resp_data_q  <= resp_data_d;
        resp_stat_q  <= resp_stat_d;
        io_addr_q    <= io_addr_d;
        io_mosi_q    <= io_mosi_d;
        io_wr_q      <= io_wr_d;
        io_rd_q      <= io_rd_d;
      end
    end
  end

  assign AReqReady  = ready_q;
  assign ARespValid = resp_valid_q;
  assign ARespData  = resp_data_q;
  assign ARespStat  = resp_stat_q;
  assign AIoAddr    = io_addr_q;
  assign AIoMosi    = io_mosi_q;
  assign AIoWrSize  = io_wr_q;
  assign AIoRdSize  = io_rd_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: directed cases plus randomized transactions checked
// against a transaction-level model of strobe length, status and read data.
module tb_io_bus_master;

  localparam int unsigned TO   = 4;
  localparam logic [15:0] MASK = 16'h3FFF;

  typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [3:0]  req_size = '0;
  logic [15:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_data;
  logic [1:0]  resp_stat;
  logic [15:0] io_addr;
  logic [63:0] io_mosi;
  logic [3:0]  io_wr;
  logic [3:0]  io_rd;
  logic [63:0] io_miso = '0;
  logic        io_ack = 1'b0;
  logic        io_err = 1'b0;

  int  errors = 0;
  int  checks = 0;
  bit  en_rand = 1'b0;

  always #5 clk = ~clk;

  io_bus_master #(.CTimeout(TO), .CAddrMask(MASK)) dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en),
    .AReqValid(req_valid), .AReqReady(req_ready), .AReqWr(req_wr),
    .AReqSize(req_size), .AReqAddr(req_addr), .AReqData(req_data),
    .ARespValid(resp_valid), .ARespReady(resp_ready),
    .ARespData(resp_data), .ARespStat(resp_stat),
    .AIoAddr(io_addr), .AIoMosi(io_mosi), .AIoWrSize(io_wr), .AIoRdSize(io_rd),
    .AIoMiso(io_miso), .AIoAddrAck(io_ack), .AIoAddrErr(io_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enabled edge, optionally preceded by a few disabled edges.
  task automatic tick();
    if (en_rand) begin
      int k;
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) begin
        en = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] width_mask(input logic [3:0] s);
    case (s)
      4'b0001: return 64'hFF;
      4'b0010: return 64'hFFFF;
      4'b0100: return 64'hFFFF_FFFF;
      4'b1000: return '1;
      default: return '0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_rvalid"}, 64'(resp_valid), 64'(0));
    check({tag, "_rdata"}, resp_data, 64'(0));
    check({tag, "_rstat"}, 64'(resp_stat), 64'(0));
    check({tag, "_addr"}, 64'(io_addr), 64'(0));
    check({tag, "_mosi"}, io_mosi, 64'(0));
    check({tag, "_wr"}, 64'(io_wr), 64'(0));
    check({tag, "_rd"}, 64'(io_rd), 64'(0));
  endtask

  // Full transaction: responder reacts (kind) in ACCESS cycle d, client holds off 'hold' cycles.
  task automatic run_txn(input bit wr, input logic [3:0] size, input logic [15:0] addr,
                         input logic [63:0] data, input kind_e kind, input int d,
                         input logic [63:0] miso, input int hold);
    int          s;
    logic [1:0]  est;
    logic [63:0] edata;

    if ($countones(size) != 1) begin
      s = 0; est = 2'd3; edata = '0;
    end else if (kind == K_NONE || d >= int'(TO)) begin
      s = int'(TO); est = 2'd2; edata = '0;
    end else begin
      s = d + 1;
      est = (kind == K_ACK) ? 2'd0 : 2'd1;
      edata = (kind == K_ACK && !wr) ? (miso & width_mask(size)) : 64'(0);
    end

    check("idle_ready", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_wr = wr; req_size = size; req_addr = addr; req_data = data;
    tick();
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_size = 4'($urandom); req_addr = 16'($urandom);
    req_data = {$urandom, $urandom};

    for (int n = 0; n < s; n++) begin
      check("wr_strobe", 64'(io_wr), 64'(wr ? size : 4'b0));
      check("rd_strobe", 64'(io_rd), 64'(wr ? 4'b0 : size));
      check("busy_ready", 64'(req_ready), 64'(0));
      check("busy_rvalid", 64'(resp_valid), 64'(0));
      if (n == 0) begin
        check("io_addr", 64'(io_addr), 64'(addr & MASK));
        check("io_mosi", io_mosi, data);
      end
      io_miso = (n == d) ? miso : {$urandom, $urandom};
      io_ack  = (n == d) && (kind == K_ACK || kind == K_BOTH);
      io_err  = (n == d) && (kind == K_ERR || kind == K_BOTH);
      tick();
      io_ack = 1'b0;
      io_err = 1'b0;
    end

    check("wr_strobe_off", 64'(io_wr), 64'(0));
    check("rd_strobe_off", 64'(io_rd), 64'(0));
    for (int h = 0; h <= hold; h++) begin
      check("resp_valid", 64'(resp_valid), 64'(1));
      check("resp_stat", 64'(resp_stat), 64'(est));
      check("resp_data", resp_data, edata);
      check("resp_ready_block", 64'(req_ready), 64'(0));
      if (h == hold) resp_ready = 1'b1;
      tick();
    end
    resp_ready = 1'b0;
    check("resp_done", 64'(resp_valid), 64'(0));
    check("ready_after", 64'(req_ready), 64'(1));
  endtask

  initial begin
    // Power-on reset.
    rst = 1'b1;
    tick();
    tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();
    check("por_ready_idle", 64'(req_ready), 64'(1));

    // Directed cases.
    run_txn(1'b1, 4'b0010, 16'h0010, 64'h1234, K_ACK, 0, 64'h0, 0);
    run_txn(1'b0, 4'b0001, 16'h0000, 64'h0, K_ACK, 0, 64'hFFFF_FFFF_FFFF_FFA5, 0);
    run_txn(1'b0, 4'b0100, 16'h0030, 64'h0, K_BOTH, 0, 64'hDEAD_BEEF_CAFE_F00D, 0);
    run_txn(1'b0, 4'b1000, 16'hC123, 64'h0, K_NONE, 0, 64'h0, 5);
    run_txn(1'b1, 4'b0011, 16'h0040, 64'h55, K_ACK, 0, 64'h0, 0);
    run_txn(1'b0, 4'b0000, 16'h0050, 64'h0, K_ACK, 0, 64'h0, 1);
    run_txn(1'b0, 4'b0100, 16'hFFFF, 64'h0, K_ACK, int'(TO) - 1, 64'h0123_4567_89AB_CDEF, 0);

    // Reset in the middle of ACCESS with the enable toggling.
    req_valid = 1'b1; req_wr = 1'b0; req_size = 4'b0100; req_addr = 16'h0200;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    check("rst_gated_hold", 64'(io_rd), 64'(4'b0100));
    en = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("mid");
    rst = 1'b0;
    for (int i = 0; i < int'(TO) + 2; i++) begin
      tick();
      check("mid_no_resp", 64'(resp_valid), 64'(0));
    end
    check("mid_ready", 64'(req_ready), 64'(1));
    run_txn(1'b0, 4'b0010, 16'h0204, 64'h0, K_ACK, 1, 64'h9999_8888_7777_ABCD, 0);

    // Randomized transactions with gated clock enable.
    en_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] sz;
      kind_e      kd;
      sz = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      kd = kind_e'($urandom_range(0, 3));
      run_txn(1'($urandom), sz, 16'($urandom), {$urandom, $urandom}, kd,
              $urandom_range(0, TO), {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
